// File: rtl/writeback_controller.sv
// Writeback arbiter: owns the scalar (rf) and vector (vrf) register-file write ports, queueing
// vector-tail results in program order. Define WB_ERR_CHECK_EN to build the sticky wb_err checker.

module wb_lane #(
    parameter int DW        = 32,
    parameter int BUF_DEPTH = 2
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic                         s_wr_en_i,
    input  logic [4:0]                   s_waddr_i,
    input  logic [DW-1:0]                s_wdata_i,
    input  logic                         v_wr_en_i,
    input  logic [4:0]                   v_waddr_i,
    input  logic [DW-1:0]                v_wdata_i,
    input  logic                         buffer_i,
    input  logic                         wb_sel_i,
    output logic                         wr_en_o,
    output logic [4:0]                   waddr_o,
    output logic [DW-1:0]                wdata_o,
    output logic                         busy_o,
    output logic [$clog2(BUF_DEPTH):0]   count_o
`ifdef WB_ERR_CHECK_EN
    ,
    output logic                         overflow_o,
    output logic                         lost_o
`endif
);
    localparam int PW = $clog2(BUF_DEPTH);
    localparam int CW = PW + 1;
    localparam int EW = 5 + DW;
    localparam logic [CW-1:0] FULL_CNT = CW'(BUF_DEPTH);

    typedef enum logic [1:0] {
        SRC_IDLE,
        SRC_SCALAR,
        SRC_QUEUE,
        SRC_VECTOR
    } src_e;

    src_e            src;
    logic            v_valid;
    logic            push;
    logic            pop;
    logic            full;
    logic            overflow;
    logic            do_push;
    logic [EW-1:0]   head_entry;

    logic [EW-1:0]   mem_q [BUF_DEPTH];
    logic [PW-1:0]   head_q, head_d;
    logic [PW-1:0]   tail_q, tail_d;
    logic [CW-1:0]   count_q, count_d;
    logic            wr_en_q, wr_en_d;
    logic [4:0]      waddr_q, waddr_d;
    logic [DW-1:0]   wdata_q, wdata_d;

    assign v_valid    = v_wr_en_i & wb_sel_i;
    assign head_entry = mem_q[head_q];

    // Source priority: capture > drain queue > direct vector > scalar > idle.
    always_comb begin
        src  = SRC_IDLE;
        push = 1'b0;
        pop  = 1'b0;
        if (buffer_i) begin
            push = v_wr_en_i;
            if (s_wr_en_i) begin
                src = SRC_SCALAR;
            end
        end else if (count_q != '0) begin
            pop  = 1'b1;
            push = v_valid;
            src  = SRC_QUEUE;
        end else if (v_valid) begin
            src = SRC_VECTOR;
        end else if (s_wr_en_i) begin
            src = SRC_SCALAR;
        end
    end

    // A full queue can only be pushed without a pop during capture; that entry is dropped.
    assign full     = (count_q == FULL_CNT);
    assign overflow = push & ~pop & full;
    assign do_push  = push & ~overflow;

    always_comb begin
        head_d  = head_q + PW'(pop);
        tail_d  = tail_q + PW'(do_push);
        count_d = count_q + CW'(do_push) - CW'(pop);
        wr_en_d = 1'b0;
        waddr_d = waddr_q;
        wdata_d = wdata_q;
        case (src)
            SRC_SCALAR: begin
                wr_en_d = 1'b1;
                waddr_d = s_waddr_i;
                wdata_d = s_wdata_i;
            end
            SRC_QUEUE: begin
                wr_en_d = 1'b1;
                waddr_d = head_entry[EW-1:DW];
                wdata_d = head_entry[DW-1:0];
            end
            SRC_VECTOR: begin
                wr_en_d = 1'b1;
                waddr_d = v_waddr_i;
                wdata_d = v_wdata_i;
            end
            default: begin
                wr_en_d = 1'b0;
            end
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            head_q  <= '0;
            tail_q  <= '0;
            count_q <= '0;
            wr_en_q <= 1'b0;
            waddr_q <= '0;
            wdata_q <= '0;
        end else begin
            head_q  <= head_d;
            tail_q  <= tail_d;
            count_q <= count_d;
            wr_en_q <= wr_en_d;
            waddr_q <= waddr_d;
            wdata_q <= wdata_d;
        end
    end

    // Storage carries no reset so it maps onto plain RAM; stale contents are unreachable once pointers clear.
    always_ff @(posedge clk) begin
        if (do_push) begin
            mem_q[tail_q] <= {v_waddr_i, v_wdata_i};
        end
    end

    assign wr_en_o = wr_en_q;
    assign waddr_o = waddr_q;
    assign wdata_o = wdata_q;
    assign busy_o  = (count_q != '0);
    assign count_o = count_q;

`ifdef WB_ERR_CHECK_EN
    assign overflow_o = overflow;
    assign lost_o     = s_wr_en_i & ((src == SRC_QUEUE) | (src == SRC_VECTOR));
`endif

endmodule

module writeback_controller #(
    parameter int XLEN      = 32,
    parameter int VLEN      = 128,
    parameter int BUF_DEPTH = 2
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic                         s_reg_wr_en,
    input  logic [4:0]                   s_reg_waddr,
    input  logic [XLEN-1:0]              s_reg_wdata,
    input  logic                         s_vec_wr_en,
    input  logic [4:0]                   s_vec_waddr,
    input  logic [VLEN-1:0]              s_vec_wdata,
    input  logic                         v_reg_wr_en,
    input  logic [4:0]                   v_reg_waddr,
    input  logic [XLEN-1:0]              v_reg_wdata,
    input  logic                         v_vec_wr_en,
    input  logic [4:0]                   v_vec_waddr,
    input  logic [VLEN-1:0]              v_vec_wdata,
    input  logic                         buffer_register,
    input  logic                         buffer_vector,
    input  logic                         register_wb_sel,
    input  logic                         vector_wb_sel,
    output logic                         rf_wr_en,
    output logic [4:0]                   rf_waddr,
    output logic [XLEN-1:0]              rf_wdata,
    output logic                         vrf_wr_en,
    output logic [4:0]                   vrf_waddr,
    output logic [VLEN-1:0]              vrf_wdata,
    output logic                         reg_q_busy,
    output logic                         vec_q_busy,
    output logic [$clog2(BUF_DEPTH):0]   reg_q_count,
    output logic [$clog2(BUF_DEPTH):0]   vec_q_count,
    output logic                         wb_err
);

`ifdef WB_ERR_CHECK_EN
    logic reg_ovf, reg_lost, vec_ovf, vec_lost;
    logic wb_err_q;
`endif

    wb_lane #(.DW(XLEN), .BUF_DEPTH(BUF_DEPTH)) u_reg_lane (
        .clk        (clk),
        .rst        (rst),
        .s_wr_en_i  (s_reg_wr_en),
        .s_waddr_i  (s_reg_waddr),
        .s_wdata_i  (s_reg_wdata),
        .v_wr_en_i  (v_reg_wr_en),
        .v_waddr_i  (v_reg_waddr),
        .v_wdata_i  (v_reg_wdata),
        .buffer_i   (buffer_register),
        .wb_sel_i   (register_wb_sel),
        .wr_en_o    (rf_wr_en),
        .waddr_o    (rf_waddr),
        .wdata_o    (rf_wdata),
        .busy_o     (reg_q_busy),
        .count_o    (reg_q_count)
`ifdef WB_ERR_CHECK_EN
        ,
        .overflow_o (reg_ovf),
        .lost_o     (reg_lost)
`endif
    );

    wb_lane #(.DW(VLEN), .BUF_DEPTH(BUF_DEPTH)) u_vec_lane (
        .clk        (clk),
        .rst        (rst),
        .s_wr_en_i  (s_vec_wr_en),
        .s_waddr_i  (s_vec_waddr),
        .s_wdata_i  (s_vec_wdata),
        .v_wr_en_i  (v_vec_wr_en),
        .v_waddr_i  (v_vec_waddr),
        .v_wdata_i  (v_vec_wdata),
        .buffer_i   (buffer_vector),
        .wb_sel_i   (vector_wb_sel),
        .wr_en_o    (vrf_wr_en),
        .waddr_o    (vrf_waddr),
        .wdata_o    (vrf_wdata),
        .busy_o     (vec_q_busy),
        .count_o    (vec_q_count)
`ifdef WB_ERR_CHECK_EN
        ,
        .overflow_o (vec_ovf),
        .lost_o     (vec_lost)
`endif
    );

`ifdef WB_ERR_CHECK_EN
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wb_err_q <= 1'b0;
        end else if (reg_ovf | reg_lost | vec_ovf | vec_lost) begin
            wb_err_q <= 1'b1;
        end
    end
    assign wb_err = wb_err_q;

`ifndef SYNTHESIS
    always @(posedge clk) begin
        if (!rst) begin
            if (reg_ovf)  $error("writeback_controller: rf queue overflow, entry dropped");
            if (vec_ovf)  $error("writeback_controller: vrf queue overflow, entry dropped");
            if (reg_lost) $error("writeback_controller: scalar rf write lost arbitration");
            if (vec_lost) $error("writeback_controller: scalar vrf write lost arbitration");
        end
    end
`endif
`else
    assign wb_err = 1'b0;
`endif

endmodule

// File: tb/tb_writeback_controller.sv
// Self-checking bench for writeback_controller: queue-based reference model, directed cases from
// the block's scenarios, then constrained-random traffic on both lanes.

module tb_writeback_controller;
    localparam int XLEN      = 32;
    localparam int VLEN      = 128;
    localparam int BUF_DEPTH = 2;
    localparam int CW        = $clog2(BUF_DEPTH) + 1;
`ifdef WB_ERR_CHECK_EN
    localparam bit ERR_EN = 1'b1;
`else
    localparam bit ERR_EN = 1'b0;
`endif

    logic clk = 1'b0;
    logic rst = 1'b1;
    logic            s_reg_wr_en, s_vec_wr_en, v_reg_wr_en, v_vec_wr_en;
    logic [4:0]      s_reg_waddr, s_vec_waddr, v_reg_waddr, v_vec_waddr;
    logic [XLEN-1:0] s_reg_wdata, v_reg_wdata;
    logic [VLEN-1:0] s_vec_wdata, v_vec_wdata;
    logic            buffer_register, buffer_vector, register_wb_sel, vector_wb_sel;
    logic            rf_wr_en, vrf_wr_en, reg_q_busy, vec_q_busy, wb_err;
    logic [4:0]      rf_waddr, vrf_waddr;
    logic [XLEN-1:0] rf_wdata;
    logic [VLEN-1:0] vrf_wdata;
    logic [CW-1:0]   reg_q_count, vec_q_count;

    writeback_controller #(.XLEN(XLEN), .VLEN(VLEN), .BUF_DEPTH(BUF_DEPTH)) dut (
        .clk(clk), .rst(rst),
        .s_reg_wr_en(s_reg_wr_en), .s_reg_waddr(s_reg_waddr), .s_reg_wdata(s_reg_wdata),
        .s_vec_wr_en(s_vec_wr_en), .s_vec_waddr(s_vec_waddr), .s_vec_wdata(s_vec_wdata),
        .v_reg_wr_en(v_reg_wr_en), .v_reg_waddr(v_reg_waddr), .v_reg_wdata(v_reg_wdata),
        .v_vec_wr_en(v_vec_wr_en), .v_vec_waddr(v_vec_waddr), .v_vec_wdata(v_vec_wdata),
        .buffer_register(buffer_register), .buffer_vector(buffer_vector),
        .register_wb_sel(register_wb_sel), .vector_wb_sel(vector_wb_sel),
        .rf_wr_en(rf_wr_en), .rf_waddr(rf_waddr), .rf_wdata(rf_wdata),
        .vrf_wr_en(vrf_wr_en), .vrf_waddr(vrf_waddr), .vrf_wdata(vrf_wdata),
        .reg_q_busy(reg_q_busy), .vec_q_busy(vec_q_busy),
        .reg_q_count(reg_q_count), .vec_q_count(vec_q_count),
        .wb_err(wb_err)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    // Reference state: pending entries per lane as {addr, data}, expected port values, sticky error.
    logic [VLEN+4:0] q_reg[$];
    logic [VLEN+4:0] q_vec[$];
    logic            exp_en[2];
    logic [4:0]      exp_addr[2];
    logic [VLEN-1:0] exp_data[2];
    logic            exp_err;

    task automatic check(input string name, input logic [VLEN-1:0] act, input logic [VLEN-1:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s: got %h required %h", name, act, req);
        end
    endtask

    task automatic model_reset();
        q_reg.delete();
        q_vec.delete();
        for (int i = 0; i < 2; i++) begin
            exp_en[i]   = 1'b0;
            exp_addr[i] = '0;
            exp_data[i] = '0;
        end
        exp_err = 1'b0;
    endtask

    task automatic model_lane(input int ln, input logic bufx, input logic sel, input logic s_en,
                              input logic [4:0] s_a, input logic [VLEN-1:0] s_d, input logic v_en,
                              input logic [4:0] v_a, input logic [VLEN-1:0] v_d);
        logic [VLEN+4:0] q[$];
        logic [VLEN+4:0] head;
        logic            bad;
        bad = 1'b0;
        if (ln == 0) q = q_reg; else q = q_vec;
        exp_en[ln] = 1'b0;
        if (bufx) begin
            if (v_en) begin
                if (q.size() < BUF_DEPTH) q.push_back({v_a, v_d});
                else bad = 1'b1;
            end
            if (s_en) begin
                exp_en[ln] = 1'b1; exp_addr[ln] = s_a; exp_data[ln] = s_d;
            end
        end else if (q.size() > 0) begin
            head = q.pop_front();
            exp_en[ln] = 1'b1; exp_addr[ln] = head[VLEN+4:VLEN]; exp_data[ln] = head[VLEN-1:0];
            if (v_en && sel) q.push_back({v_a, v_d});
            if (s_en) bad = 1'b1;
        end else if (v_en && sel) begin
            exp_en[ln] = 1'b1; exp_addr[ln] = v_a; exp_data[ln] = v_d;
            if (s_en) bad = 1'b1;
        end else if (s_en) begin
            exp_en[ln] = 1'b1; exp_addr[ln] = s_a; exp_data[ln] = s_d;
        end
        if (bad) exp_err = 1'b1;
        if (ln == 0) q_reg = q; else q_vec = q;
    endtask

    task automatic compare_all();
        check("rf_wr_en",    VLEN'(rf_wr_en),    VLEN'(exp_en[0]));
        check("rf_waddr",    VLEN'(rf_waddr),    VLEN'(exp_addr[0]));
        check("rf_wdata",    VLEN'(rf_wdata),    exp_data[0]);
        check("vrf_wr_en",   VLEN'(vrf_wr_en),   VLEN'(exp_en[1]));
        check("vrf_waddr",   VLEN'(vrf_waddr),   VLEN'(exp_addr[1]));
        check("vrf_wdata",   vrf_wdata,          exp_data[1]);
        check("reg_q_count", VLEN'(reg_q_count), VLEN'(q_reg.size()));
        check("vec_q_count", VLEN'(vec_q_count), VLEN'(q_vec.size()));
        check("reg_q_busy",  VLEN'(reg_q_busy),  VLEN'(q_reg.size() != 0));
        check("vec_q_busy",  VLEN'(vec_q_busy),  VLEN'(q_vec.size() != 0));
        check("wb_err",      VLEN'(wb_err),      VLEN'(ERR_EN & exp_err));
    endtask

    // One clock of traffic: model consumes the current inputs, then outputs are compared after the edge.
    task automatic step();
        model_lane(0, buffer_register, register_wb_sel, s_reg_wr_en, s_reg_waddr, VLEN'(s_reg_wdata),
                   v_reg_wr_en, v_reg_waddr, VLEN'(v_reg_wdata));
        model_lane(1, buffer_vector, vector_wb_sel, s_vec_wr_en, s_vec_waddr, s_vec_wdata,
                   v_vec_wr_en, v_vec_waddr, v_vec_wdata);
        @(posedge clk);
        #1;
        compare_all();
    endtask

    task automatic set_idle();
        s_reg_wr_en = 0; s_reg_waddr = '0; s_reg_wdata = '0;
        s_vec_wr_en = 0; s_vec_waddr = '0; s_vec_wdata = '0;
        v_reg_wr_en = 0; v_reg_waddr = '0; v_reg_wdata = '0;
        v_vec_wr_en = 0; v_vec_waddr = '0; v_vec_wdata = '0;
        buffer_register = 0; buffer_vector = 0; register_wb_sel = 0; vector_wb_sel = 0;
    endtask

    initial begin
        set_idle();
        model_reset();
        repeat (2) @(posedge clk);
        #1;
        compare_all();
        check("reset_rf_wr_en", VLEN'(rf_wr_en), '0);
        rst = 1'b0;

        // Plain scalar rf write.
        s_reg_wr_en = 1; s_reg_waddr = 5'd5; s_reg_wdata = 32'h11;
        step();
        check("t1_rf_wr_en", VLEN'(rf_wr_en), VLEN'(1));
        check("t1_rf_waddr", VLEN'(rf_waddr), VLEN'(5));
        check("t1_rf_wdata", VLEN'(rf_wdata), VLEN'(32'h11));
        check("t1_busy",     VLEN'(reg_q_busy), '0);

        // Capture vector result behind a scalar write to the same register.
        set_idle();
        buffer_register = 1; s_reg_wr_en = 1; s_reg_waddr = 5'd3; s_reg_wdata = 32'hA;
        v_reg_wr_en = 1; v_reg_waddr = 5'd3; v_reg_wdata = 32'hB;
        step();
        check("t2_wdata_a", VLEN'(rf_wdata), VLEN'(32'hA));
        check("t2_busy",    VLEN'(reg_q_busy), VLEN'(1));
        set_idle();
        step();
        check("t2_wdata_b", VLEN'(rf_wdata), VLEN'(32'hB));
        check("t2_count",   VLEN'(reg_q_count), '0);

        // Vector lane: captured entry drains ahead of a following direct result.
        set_idle();
        buffer_vector = 1; v_vec_wr_en = 1; v_vec_waddr = 5'd7; v_vec_wdata = 128'h7777;
        step();
        check("t3_count0", VLEN'(vec_q_count), VLEN'(1));
        set_idle();
        vector_wb_sel = 1; v_vec_wr_en = 1; v_vec_waddr = 5'd8; v_vec_wdata = 128'h8888;
        step();
        check("t3_addr7",  VLEN'(vrf_waddr), VLEN'(7));
        check("t3_count1", VLEN'(vec_q_count), VLEN'(1));
        set_idle();
        step();
        check("t3_addr8",  VLEN'(vrf_waddr), VLEN'(8));
        check("t3_count2", VLEN'(vec_q_count), '0);

        // Both lanes in the same cycle.
        set_idle();
        s_reg_wr_en = 1; s_reg_waddr = 5'd9; s_reg_wdata = 32'hCAFE;
        vector_wb_sel = 1; v_vec_wr_en = 1; v_vec_waddr = 5'd12; v_vec_wdata = {4{32'hBEEF0001}};
        step();
        check("t4_rf_en",  VLEN'(rf_wr_en), VLEN'(1));
        check("t4_vrf_en", VLEN'(vrf_wr_en), VLEN'(1));
        check("t4_vrf_d",  vrf_wdata, {4{32'hBEEF0001}});

        // Legal random traffic: no lost scalar writes and no overflowing captures.
        for (int n = 0; n < 400; n++) begin
            buffer_register = ($urandom_range(0, 3) == 0);
            register_wb_sel = $urandom_range(0, 1);
            v_reg_wr_en     = $urandom_range(0, 1);
            s_reg_wr_en     = $urandom_range(0, 1);
            s_reg_waddr = 5'($urandom); s_reg_wdata = $urandom;
            v_reg_waddr = 5'($urandom); v_reg_wdata = $urandom;
            if (buffer_register && v_reg_wr_en && q_reg.size() == BUF_DEPTH) buffer_register = 0;
            if (!buffer_register && (q_reg.size() > 0 || (v_reg_wr_en && register_wb_sel))) s_reg_wr_en = 0;

            buffer_vector = ($urandom_range(0, 3) == 0);
            vector_wb_sel = $urandom_range(0, 1);
            v_vec_wr_en   = $urandom_range(0, 1);
            s_vec_wr_en   = $urandom_range(0, 1);
            s_vec_waddr = 5'($urandom); s_vec_wdata = {$urandom, $urandom, $urandom, $urandom};
            v_vec_waddr = 5'($urandom); v_vec_wdata = {$urandom, $urandom, $urandom, $urandom};
            if (buffer_vector && v_vec_wr_en && q_vec.size() == BUF_DEPTH) buffer_vector = 0;
            if (!buffer_vector && (q_vec.size() > 0 || (v_vec_wr_en && vector_wb_sel))) s_vec_wr_en = 0;
            step();
        end

        set_idle();
        repeat (3) step();
        check("drained", VLEN'(reg_q_count), '0);

        // Three captures into a two-entry queue: the third is dropped.
        for (int i = 0; i < 3; i++) begin
            set_idle();
            buffer_register = 1; v_reg_wr_en = 1; v_reg_waddr = 5'(20 + i); v_reg_wdata = 32'(100 + i);
            step();
        end
        check("ovf_count", VLEN'(reg_q_count), VLEN'(2));
        check("ovf_err",   VLEN'(wb_err), VLEN'(ERR_EN));
        set_idle();
        step();
        check("ovf_pop0", VLEN'(rf_waddr), VLEN'(20));
        step();
        check("ovf_pop1", VLEN'(rf_waddr), VLEN'(21));
        step();
        check("ovf_no_third", VLEN'(rf_wr_en), '0);

        // Refill, then reset asynchronously mid-cycle with both entries pending.
        for (int i = 0; i < 2; i++) begin
            set_idle();
            buffer_register = 1; s_reg_wr_en = 1; s_reg_waddr = 5'd1; s_reg_wdata = 32'h5;
            v_reg_wr_en = 1; v_reg_waddr = 5'(24 + i); v_reg_wdata = 32'(200 + i);
            step();
        end
        check("pre_rst_count", VLEN'(reg_q_count), VLEN'(2));
        set_idle();
        #2 rst = 1'b1;
        #1;
        check("rst_count", VLEN'(reg_q_count), '0);
        check("rst_busy",  VLEN'(reg_q_busy), '0);
        check("rst_rf_en", VLEN'(rf_wr_en), '0);
        check("rst_vrf_en", VLEN'(vrf_wr_en), '0);
        check("rst_err",   VLEN'(wb_err), '0);
        model_reset();
        @(posedge clk);
        #1;
        compare_all();
        rst = 1'b0;

        s_reg_wr_en = 1; s_reg_waddr = 5'd6; s_reg_wdata = 32'h66;
        step();
        check("post_rst_addr", VLEN'(rf_waddr), VLEN'(6));
        check("post_rst_data", VLEN'(rf_wdata), VLEN'(32'h66));
        set_idle();
        step();

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
